change_dispenser: RTL and testbench

Coin-return stage sitting directly downstream of the vending controller's change outputs (`change_due`, change-return start). It latches a change amount, decomposes it greedily into 5-, 2- and 1-unit coins, and drives one timed solenoid pulse per coin on the matching eject line. It reports `busy` while dispensing and pulses `done` on completion, so the top level can drive eject hardware (Pmod header) and confirm refund completion.

---
 rtl/change_dispenser.sv | 111 +++++++++++
 tb/tb_change_dispenser.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy 5/2/1 coin ejector with timed solenoid pulses
// Define CHANGE_DISPENSER_TALLY_EN to build the coins_total counter; otherwise it is tied to 0.
module change_dispenser #(
   parameter int PULSE_CYCLES = 5_000_000,
   parameter int GAP_CYCLES   = 5_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] amount,
   output logic       eject5,
   output logic       eject2,
   output logic       eject1,
   output logic       busy,
   output logic       done,
   output logic [7:0] remaining,
   output logic [7:0] coins_total
);

   typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

   localparam logic [31:0] PULSE_LOAD = 32'(PULSE_CYCLES - 1);
   localparam logic [31:0] GAP_LOAD   = 32'(GAP_CYCLES - 1);

   state_t      state, state_nxt;
   logic [31:0] cnt;
   logic        cnt_zero;
   logic [7:0]  coin_val;
   logic        pulse_end;

   assign cnt_zero  = (cnt == 32'd0);
   assign pulse_end = (state == PULSE) && cnt_zero;

   always_comb begin
      case ({eject5, eject2, eject1})
         3'b100:  coin_val = 8'd5;
         3'b010:  coin_val = 8'd2;
         3'b001:  coin_val = 8'd1;
         default: coin_val = 8'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (start) state_nxt = (amount != 8'd0) ? SELECT : DONE;
         SELECT: state_nxt = PULSE;
         PULSE:  if (cnt_zero) state_nxt = GAP;
         GAP:    if (cnt_zero) state_nxt = (remaining == 8'd0) ? DONE : SELECT;
         DONE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // done trails the DONE state by one cycle so it is a clean registered pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         remaining <= '0;
         eject5    <= 1'b0;
         eject2    <= 1'b0;
         eject1    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= (state == DONE);
         busy <= (state_nxt == SELECT) || (state_nxt == PULSE) || (state_nxt == GAP);
         case (state)
            IDLE: begin
               if (start && amount != 8'd0) remaining <= amount;
            end
            SELECT: begin
               cnt    <= PULSE_LOAD;
               eject5 <= (remaining >= 8'd5);
               eject2 <= (remaining < 8'd5) && (remaining >= 8'd2);
               eject1 <= (remaining < 8'd2);
            end
            PULSE: begin
               if (cnt_zero) begin
                  eject5    <= 1'b0;
                  eject2    <= 1'b0;
                  eject1    <= 1'b0;
                  remaining <= remaining - coin_val;
                  cnt       <= GAP_LOAD;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            GAP: begin
               if (!cnt_zero) cnt <= cnt - 32'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef CHANGE_DISPENSER_TALLY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           coins_total <= '0;
      else if (pulse_end) coins_total <= coins_total + 8'd1;
   end
`else
   assign coins_total = 8'd0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - scoreboard bench for change_dispenser
module tb_change_dispenser;
   localparam int P = 4;
   localparam int G = 2;
   localparam int C = 1 + P + G;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] amount = 8'd0;
   logic       eject5, eject2, eject1, busy, done;
   logic [7:0] remaining, coins_total;

   change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
      .clk(clk), .rst(rst), .start(start), .amount(amount),
      .eject5(eject5), .eject2(eject2), .eject1(eject1),
      .busy(busy), .done(done), .remaining(remaining), .coins_total(coins_total)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {int coin; int rise; int rem_after;} coin_t;
   typedef struct {int cyc; int tally;} done_t;
   coin_t coin_q[$];
   done_t done_q[$];
   int checks = 0;
   int errors = 0;
   int tally_model = 0;
   bit noise = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Greedy change-making from plain arithmetic: as many 5s as fit, then 2s, then 1s.
   task automatic push_model(input int a, input int k, output int n);
      int n5, n2, n1, rem;
      coin_t c;
      done_t d;
      n5 = a / 5;
      n2 = (a % 5) / 2;
      n1 = (a % 5) % 2;
      rem = a;
      n = 0;
      for (int i = 0; i < n5 + n2 + n1; i++) begin
         c.coin = (i < n5) ? 5 : (i < n5 + n2) ? 2 : 1;
         rem -= c.coin;
         c.rise = k + 1 + n * C;
         c.rem_after = rem;
         coin_q.push_back(c);
         n++;
      end
`ifdef CHANGE_DISPENSER_TALLY_EN
      tally_model = (tally_model + n) % 256;
`else
      tally_model = 0;
`endif
      d.cyc = (a == 0) ? k + 1 : k + n * C + 1;
      d.tally = tally_model;
      done_q.push_back(d);
   endtask

   task automatic issue(input int a);
      int k, n, lim;
      bit saw, busy_seen;
      @(negedge clk);
      start = 1'b1;
      amount = 8'(a);
      k = cyc + 1;
      push_model(a, k, n);
      @(negedge clk);
      start = 1'b0;
      amount = 8'($urandom);
      saw = 0;
      busy_seen = 0;
      lim = n * C + 10;
      for (int t = 0; t < lim && !saw; t++) begin
         if (busy) busy_seen = 1;
         if (done) begin
            saw = 1;
            start = 1'b0;
         end else begin
            if (noise && busy && $urandom_range(0, 2) == 0) begin
               start = 1'b1;
               amount = 8'($urandom);
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
         end
      end
      start = 1'b0;
      chk("done_seen", int'(saw), 1);
      if (a == 0) chk("busy_on_zero", int'(busy_seen), 0);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_eject5"}, int'(eject5), 0);
      chk({tag, "_eject2"}, int'(eject2), 0);
      chk({tag, "_eject1"}, int'(eject1), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_remaining"}, int'(remaining), 0);
      chk({tag, "_coins_total"}, int'(coins_total), 0);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check_all_zero("async_reset");
      coin_q.delete();
      done_q.delete();
      tally_model = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic reset_mid_pulse();
      int k, n;
      bit saw;
      @(negedge clk);
      start = 1'b1;
      amount = 8'd7;
      k = cyc + 1;
      push_model(7, k, n);
      @(negedge clk);
      start = 1'b0;
      saw = 0;
      for (int t = 0; t < 10 && !saw; t++) begin
         if (eject5) saw = 1;
         else @(negedge clk);
      end
      chk("reset_test_eject5_seen", int'(saw), 1);
      @(negedge clk);
      reset_pulse();
   endtask

   // Monitor: pops expected coins on each eject rise, and expected completions on done.
   logic [2:0] prev_ej = 3'b000;
   int hi_len = 0;
   coin_t cur;
   always @(negedge clk) begin
      logic [2:0] ej;
      int cv;
      done_t d;
      if (!rst) begin
         prev_ej = 3'b000;
         hi_len = 0;
      end else begin
         ej = {eject5, eject2, eject1};
         cv = (ej == 3'b100) ? 5 : (ej == 3'b010) ? 2 : (ej == 3'b001) ? 1 : 0;
         if (ej != 3'b000) chk("eject_onehot", $countones(ej), 1);
         if (prev_ej == 3'b000 && ej != 3'b000) begin
            if (coin_q.size() == 0) begin
               chk("unexpected_eject", cv, 0);
            end else begin
               cur = coin_q.pop_front();
               chk("coin_value", cv, cur.coin);
               chk("coin_rise_cycle", cyc, cur.rise);
            end
            hi_len = 1;
         end else if (ej != 3'b000) begin
            hi_len++;
            chk("eject_stable", int'(ej), int'(prev_ej));
         end
         if (prev_ej != 3'b000 && ej == 3'b000) begin
            chk("pulse_width", hi_len, P);
            chk("remaining_after_coin", int'(remaining), cur.rem_after);
         end
         prev_ej = ej;
         if (done) begin
            if (done_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               d = done_q.pop_front();
               chk("done_cycle", cyc, d.cyc);
               chk("coins_total_at_done", int'(coins_total), d.tally);
               chk("busy_at_done", int'(busy), 0);
               chk("remaining_at_done", int'(remaining), 0);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      issue(8);
      issue(0);
      issue(255);
      noise = 1;
      issue(13);
      issue(9);
      noise = 0;
      reset_mid_pulse();
      issue(7);
      for (int i = 0; i < 6; i++) begin
         noise = bit'($urandom_range(0, 1));
         issue(int'($urandom_range(0, 40)));
      end
      noise = 0;
      issue(1);
      issue(2);
      issue(4);
      reset_pulse();
      for (int i = 0; i < 6; i++) issue(255);
`ifdef CHANGE_DISPENSER_TALLY_EN
      chk("tally_wrap", int'(coins_total), 50);
`else
      chk("tally_disabled", int'(coins_total), 0);
`endif
      repeat (3) @(negedge clk);
      chk("coin_queue_empty", coin_q.size(), 0);
      chk("done_queue_empty", done_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
